half_adder_unit: RTL and testbench
==================================

Name: half_adder_unit

Overview:
- Registered bank of WIDTH independent 1-bit half adders.
- Per lane: out = in0 XOR in1 (sum), car = in0 AND in1 (carry).
- Outputs are registered with a valid qualifier.
- Used as the arithmetic primitive feeding full-adder and ripple-adder stages in the ARITHMETIC group.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (1..64).
- CNT_W, 16, width of the carry-event statistics counter (optional feature only).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies in0/in1 this cycle.
- in0  input  WIDTH  operand A, one bit per lane.
- in1  input  WIDTH  operand B, one bit per lane.
- out  output  WIDTH  registered sum bits.
- car  output  WIDTH  registered carry bits.
- out_valid  output  1  out/car hold a result captured from a valid input.
- stat_clr  input  1  synchronous clear of statistics (ignored when feature is compiled out).
- carry_cnt  output  CNT_W  number of accepted inputs with any carry set (feature only; ties 0 otherwise).

Behaviour:
- Reset (rst_n low, asynchronous): out=0, car=0, out_valid=0, carry_cnt=0. All hold while rst_n is low.
- Reset release is synchronous to clk. The first capture happens on the first rising edge with rst_n high.
- Per lane i, combinational: s[i] = in0[i] ^ in1[i] and c[i] = in0[i] & in1[i].
- Truth table per lane (in0,in1 -> out,car):
  - 0,0 -> 0,0
  - 1,0 -> 1,0
  - 0,1 -> 1,0
  - 1,1 -> 0,1
- Lanes are fully independent. No carry propagates between lanes.
- Latency: exactly 1 cycle.
  - Rising edge with in_valid=1: out<=s, car<=c, out_valid<=1.
  - Rising edge with in_valid=0: out and car hold their previous values; out_valid<=0.
- No backpressure; a new input can be accepted every cycle.
- Invariant: out & car == 0 in every lane at all times.
- Inputs are sampled only at the clock edge. Input glitches between edges have no effect.
- Reset asserted mid-stream: outputs clear immediately and the in-flight result is discarded.

Optional Feature:
- Macro: HALF_ADDER_STATS_EN.
- Defined:
  - carry_cnt increments by 1 on each rising edge with in_valid=1 and |c != 0.
  - Saturates at all-ones and never wraps.
  - stat_clr=1 sets carry_cnt to 0 on the next edge; clear wins over a simultaneous increment.
  - Async reset clears carry_cnt to 0.
- Not defined: no counter logic; carry_cnt is tied to 0 and stat_clr is ignored.
- Adder datapath behaviour is identical in both builds.

Test Plan:
- Reset: hold rst_n=0 with in0=1, in1=1 toggling clk -> out=0, car=0, out_valid=0, carry_cnt=0 throughout.
- WIDTH=1 sweep with in_valid=1, applying (0,0), (1,0), (0,1), (1,1) on consecutive cycles -> one cycle later (out,car) = (0,0), (1,0), (1,0), (0,1), with out_valid=1 each cycle.
- WIDTH=4, in0=4'b1100, in1=4'b1010, in_valid=1 -> next cycle out=4'b0110, car=4'b1000, out_valid=1.
- Valid gating: a result of (out,car)=(1,0), then in_valid=0 with in0=1, in1=1 -> out=1, car=0 hold and out_valid=0.
- Async reset mid-stream: assert rst_n=0 between clock edges while out_valid=1 -> out, car and out_valid drop to 0 immediately, without a clock edge.
- Stats (HALF_ADDER_STATS_EN, CNT_W=2): five valid (1,1) inputs -> carry_cnt = 1, 2, 3, 3, 3 (saturates). Then stat_clr=1 together with another (1,1) -> carry_cnt=0.

Source files
------------

// File: rtl/half_adder_unit.sv
// Registered bank of WIDTH independent half adders with a valid qualifier.
// Define HALF_ADDER_STATS_EN to build in the saturating carry-event counter.
module half_adder_unit #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] car,
   output logic             out_valid,
   input  logic             stat_clr,
   output logic [CNT_W-1:0] carry_cnt
);

   logic [WIDTH-1:0] sum_c, carry_c;
   logic [WIDTH-1:0] out_d, out_q;
   logic [WIDTH-1:0] car_d, car_q;
   logic             valid_d, valid_q;

   assign sum_c   = in0 ^ in1;
   assign carry_c = in0 & in1;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      out_d   = out_q;
      car_d   = car_q;
      valid_d = 1'b0;
      if (in_valid) begin
         out_d   = sum_c;
         car_d   = carry_c;
         valid_d = 1'b1;
      end
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q   <= '0;
         car_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         car_q   <= car_d;
         valid_q <= valid_d;
      end
   end

   assign out       = out_q;
   assign car       = car_q;
   assign out_valid = valid_q;

`ifdef HALF_ADDER_STATS_EN
   logic [CNT_W-1:0] cnt_d, cnt_q;

   // Clear takes priority over a same-cycle increment; the count sticks at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (stat_clr) begin
         cnt_d = '0;
      end else if (in_valid && (|carry_c) && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign carry_cnt = cnt_q;
`else
   logic unused_stat_clr;

   assign unused_stat_clr = stat_clr;
   assign carry_cnt       = '0;
`endif

endmodule

// File: tb/tb_half_adder_unit.sv
// Directed bench for half_adder_unit: a 1-lane instance and a 4-lane instance with a 2-bit counter.
module tb_half_adder_unit;

`ifdef HALF_ADDER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;

   logic       v1, clr1;
   logic [0:0] a1, b1, out1, car1;
   logic       ov1;
   logic [15:0] cnt1;

   logic       v4, clr4;
   logic [3:0] a4, b4, out4, car4;
   logic       ov4;
   logic [1:0] cnt4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   half_adder_unit #(.WIDTH(1), .CNT_W(16)) u_w1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v1), .in0(a1), .in1(b1),
      .out(out1), .car(car1), .out_valid(ov1), .stat_clr(clr1), .carry_cnt(cnt1)
   );

   half_adder_unit #(.WIDTH(4), .CNT_W(2)) u_w4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4), .in0(a4), .in1(b4),
      .out(out4), .car(car4), .out_valid(ov4), .stat_clr(clr4), .carry_cnt(cnt4)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected counter value: the stats build counts, the default build is tied to zero.
   function automatic logic [63:0] ecnt(input int v);
      return STATS ? 64'(v) : 64'd0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive1(input logic v, input logic a, input logic b);
      v1 = v; a1 = a; b1 = b;
   endtask

   task automatic drive4(input logic v, input logic [3:0] a, input logic [3:0] b, input logic clr);
      v4 = v; a4 = a; b4 = b; clr4 = clr;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      clr1  = 1'b0;
      drive1(1'b1, 1'b1, 1'b1);
      drive4(1'b1, 4'hF, 4'hF, 1'b0);

      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_out1", out1, 0);
         check("rst_car1", car1, 0);
         check("rst_ov1", ov1, 0);
         check("rst_cnt1", cnt1, 0);
         check("rst_car4", car4, 0);
         check("rst_cnt4", cnt4, 0);
      end

      @(negedge clk);
      rst_n = 1'b1;
      drive1(1'b1, 1'b0, 1'b0);
      drive4(1'b0, 4'h0, 4'h0, 1'b0);
      tick();
      check("sw00_out", out1, 0); check("sw00_car", car1, 0); check("sw00_ov", ov1, 1);
      check("w4_idle_ov", ov4, 0); check("w4_idle_car", car4, 0);

      drive1(1'b1, 1'b1, 1'b0);
      tick();
      check("sw10_out", out1, 1); check("sw10_car", car1, 0); check("sw10_ov", ov1, 1);

      drive1(1'b1, 1'b0, 1'b1);
      tick();
      check("sw01_out", out1, 1); check("sw01_car", car1, 0); check("sw01_ov", ov1, 1);

      drive1(1'b1, 1'b1, 1'b1);
      tick();
      check("sw11_out", out1, 0); check("sw11_car", car1, 1); check("sw11_ov", ov1, 1);
      check("sw11_cnt1", cnt1, ecnt(1));

      drive1(1'b1, 1'b1, 1'b0);
      drive4(1'b1, 4'b1100, 4'b1010, 1'b0);
      tick();
      check("w4_out", out4, 4'b0110); check("w4_car", car4, 4'b1000); check("w4_ov", ov4, 1);
      check("w4_cnt", cnt4, ecnt(1));
      check("w4_disjoint", out4 & car4, 0);
      check("pre_gate_out", out1, 1);

      drive1(1'b0, 1'b1, 1'b1);
      drive4(1'b1, 4'b0101, 4'b1010, 1'b0);
      tick();
      check("gate_out", out1, 1); check("gate_car", car1, 0); check("gate_ov", ov1, 0);
      check("gate_cnt1", cnt1, ecnt(1));
      check("nocarry_out", out4, 4'b1111); check("nocarry_car", car4, 0);
      check("nocarry_cnt", cnt4, ecnt(1));

      drive4(1'b0, 4'hF, 4'hF, 1'b1);
      tick();
      check("clr_idle_cnt", cnt4, 0);
      check("hold_out4", out4, 4'b1111); check("hold_ov4", ov4, 0);

      for (int i = 1; i <= 5; i++) begin
         drive4(1'b1, 4'b0001, 4'b0001, 1'b0);
         tick();
         check($sformatf("sat_cnt%0d", i), cnt4, ecnt(i > 3 ? 3 : i));
         check($sformatf("sat_car%0d", i), car4, 4'b0001);
      end

      drive4(1'b1, 4'b0001, 4'b0001, 1'b1);
      tick();
      check("clr_wins_cnt", cnt4, 0);
      check("clr_wins_car", car4, 4'b0001);

      drive4(1'b1, 4'b0010, 4'b0010, 1'b0);
      tick();
      check("post_clr_cnt", cnt4, ecnt(1));

      drive1(1'b1, 1'b1, 1'b1);
      tick();
      check("pre_arst_ov", ov1, 1); check("pre_arst_car", car1, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out1", out1, 0); check("arst_car1", car1, 0); check("arst_ov1", ov1, 0);
      check("arst_car4", car4, 0); check("arst_ov4", ov4, 0); check("arst_cnt4", cnt4, 0);
      check("arst_cnt1", cnt1, 0);

      @(negedge clk);
      rst_n = 1'b1;
      drive1(1'b1, 1'b1, 1'b0);
      drive4(1'b0, 4'h0, 4'h0, 1'b0);
      tick();
      check("recap_out", out1, 1); check("recap_ov", ov1, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
